// File: rtl/la_status_reporter.sv
// Checkpoint-code reporter: queues 5-bit codes posted over LA probes and holds
// each one on the GPIO pads for at least HOLD_CYCLES+1 clocks.
//
// state | meaning
// IDLE  | nothing being shown; pads keep the last code
// SHOW  | popped code is loaded onto the pads, hold timer armed
// HOLD  | timer counting down; code must stay on the pads
module la_status_reporter #(
  parameter int CODE_W      = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [CODE_W-1:0] la_code,
  input  logic              la_toggle,
  input  logic              la_toggle_oenb,
  input  logic              la_clear,
  output logic [CODE_W-1:0] io_out,
  output logic [CODE_W-1:0] io_oeb,
  output logic              st_full,
  output logic              st_empty,
  output logic              st_overflow,
  output logic              st_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              toggle_q;
  logic              armed_q;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0] data_q, data_d;
  logic [TW-1:0]     hold_q, hold_d;
  logic [CODE_W-1:0] io_out_q, io_out_d;
  logic [CODE_W-1:0] io_oeb_q, io_oeb_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              busy_q, busy_d;

  logic push;
  logic pop;
  logic wr_en;
  logic full;
  logic empty;

  // armed_q masks the first clock after reset so toggle_q can settle first
  assign push  = armed_q && (la_toggle != toggle_q) && !la_toggle_oenb;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_d   = data_q;
    io_out_d = io_out_q;
    io_oeb_d = io_oeb_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        io_out_d = data_q;
        io_oeb_d = '0;
        hold_d   = TW'(HOLD_CYCLES - 1);
        state_d  = HOLD;
      end
      HOLD: begin
        if (hold_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SHOW;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      data_d = mem_q[rptr_q[AW-1:0]];
    end
    // Flush wins over everything but leaves the pads untouched
    if (la_clear) begin
      state_d  = IDLE;
      pop      = 1'b0;
      data_d   = data_q;
      io_out_d = io_out_q;
      io_oeb_d = io_oeb_q;
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (la_clear) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
    end else begin
      wr_en = push && (!full || pop);
      if (push && full && !pop) begin
        ovf_d = 1'b1;
      end
      if (wr_en) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
    end
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    busy_d  = (state_d != IDLE) || !empty_d;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      toggle_q <= 1'b0;
      armed_q  <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      data_q   <= '0;
      hold_q   <= '0;
      io_out_q <= '1;
      io_oeb_q <= '1;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      toggle_q <= la_toggle;
      armed_q  <= 1'b1;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= la_code;
    end
  end

  assign io_out      = io_out_q;
  assign io_oeb      = io_oeb_q;
  assign st_full     = full_q;
  assign st_empty    = empty_q;
  assign st_overflow = ovf_q;
  assign st_busy     = busy_q;

endmodule
